proc_in_fifo: RTL

Input-side buffer between an external streaming producer and the processor's input port (`io_in`, `addr_in`, `req_in`, `itr`). Absorbs samples arriving asynchronously to program flow with a valid/ready handshake. Presents the oldest sample to the processor on a data address and a status word on a status address. Raises `itr` when a programmable fill level is reached, so the program can service input in bursts.

---
 rtl/proc_in_fifo_pkg.sv | 13 +
 rtl/proc_in_fifo_ram.sv | 24 ++
 rtl/proc_in_fifo.sv | 116 +++++++++++
 3 files changed

// File: rtl/proc_in_fifo_pkg.sv
// Shared constants for the processor input FIFO.
// Status word bit positions, also used by software headers.
package proc_in_fifo_pkg;

  // count field starts at bit 0 of the status word
  localparam int ST_CNT_LSB = 0;

  // underrun flag sits in the word MSB
  function automatic int st_underrun(input int nubits);
    return nubits - 1;
  endfunction

endpackage

// File: rtl/proc_in_fifo_ram.sv
// fifo_ram: DEPTH x W register array, one sync write port,
// one async read port. Ports: clk, we, waddr, wdata, raddr, rdata.
module fifo_ram #(
  parameter int DEPTH = 8,
  parameter int W     = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/proc_in_fifo.sv
// proc_in_fifo: stream-to-processor input buffer with status word
// and fill-level interrupt.
// Ports: clk, rst (async, high); s_data/s_valid/s_ready producer side;
// req_in/addr_in/io_in processor read port; itr level interrupt.
module proc_in_fifo
  import proc_in_fifo_pkg::*;
#(
  parameter int NUBITS = 16,
  parameter int NUIOIN = 2,
  parameter int DEPTH  = 8,
  parameter int ITRLVL = 1,
  parameter int CHADDR = 0,
  parameter int STADDR = 1,
  parameter int AIW    = (NUIOIN > 1) ? $clog2(NUIOIN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUBITS-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              req_in,
  input  logic [AIW-1:0]    addr_in,
  output logic [NUBITS-1:0] io_in,
  output logic              itr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int UB = st_underrun(NUBITS);

  localparam logic [AIW-1:0] CH   = AIW'(CHADDR);
  localparam logic [AIW-1:0] ST   = AIW'(STADDR);
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);
  localparam logic [CW-1:0]  LVL  = CW'(ITRLVL);

  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  logic              underrun;
  logic              underrun_next;
  logic [NUBITS-1:0] head;
  logic [NUBITS-1:0] status;
  logic              push;
  logic              pop;
  logic              rd_ch;
  logic              rd_st;
  logic              empty;

  assign empty   = (count == '0);
  assign s_ready = !rst && (count != FULL);
  assign rd_ch   = req_in && (addr_in == CH);
  assign rd_st   = req_in && (addr_in == ST);
  assign push    = s_valid && s_ready;
  assign pop     = rd_ch && !empty;

  fifo_ram #(
    .DEPTH (DEPTH),
    .W     (NUBITS)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wp),
    .wdata (s_data),
    .raddr (rp),
    .rdata (head)
  );

  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // empty data read sets the flag; a status read clears it
  always_comb begin
    underrun_next = underrun;
    if (rd_ch && empty) underrun_next = 1'b1;
    else if (rd_st)     underrun_next = 1'b0;
  end

  always_comb begin
    status = '0;
    status[UB] = underrun;
    status[ST_CNT_LSB +: CW] = count;
  end

  always_comb begin
    io_in = '0;
    if (addr_in == CH) begin
      if (!empty) io_in = head;
    end else if (addr_in == ST) begin
      io_in = status;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      underrun <= 1'b0;
      itr      <= 1'b0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      count    <= count_next;
      underrun <= underrun_next;
      itr      <= (count_next >= LVL);
    end
  end

endmodule
